// File: rtl/alarm_clock_pkg.sv
// Shared types and wrap constants for the multi-slot alarm clock.
// Pure declarations; no latency or backpressure.
package alarm_clock_pkg;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} slot_state_e;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HRS_MOD = 24;
  localparam int DAY_MOD = 7;

  typedef struct packed {
    logic [6:0] sec;
    logic [6:0] min;
    logic [6:0] hrs;
    logic [2:0] day;
  } time_t;

  function automatic logic [6:0] wrap_inc(input logic [6:0] v, input int modv);
    return (int'(v) == modv - 1) ? 7'd0 : v + 7'd1;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: editable min/hrs/mask, match compare, ring/snooze/timeout FSM.
// State changes on the clk edge of the triggering tick; no backpressure.
module alarm_slot
  import alarm_clock_pkg::*;
#(
  parameter int SNOOZE_MIN  = 9,
  parameter int TIMEOUT_MIN = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit,
  input  logic       pulse,
  input  logic       minadv,
  input  logic       hrsadv,
  input  logic [6:0] mask_in,
  input  logic       arm,
  input  logic       clr,
  input  logic       min_tick,
  input  logic       run_tick,
  input  time_t      nxt,
  input  logic       snooze_edge,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic       ringing,
  output logic       ring_nxt
);

  logic [6:0]  mask;
  slot_state_e state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic        match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amin <= 7'd0;
      ahrs <= 7'd0;
      mask <= 7'h7F;
    end else if (edit) begin
      mask <= mask_in;
      if (pulse && minadv) amin <= wrap_inc(amin, MIN_MOD);
      if (pulse && hrsadv) ahrs <= wrap_inc(ahrs, HRS_MOD);
    end
  end

  // Compared against the time as it will be after this tick.
  assign match = run_tick && arm && (nxt.min == amin) && (nxt.hrs == ahrs) && mask[nxt.day];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (!arm || clr) begin
      state_n = IDLE;
      cnt_n   = 6'd0;
    end else if (match) begin
      state_n = RINGING;
      cnt_n   = 6'(TIMEOUT_MIN);
    end else begin
      case (state)
        RINGING: begin
          if (snooze_edge) begin
            state_n = SNOOZED;
            cnt_n   = 6'(SNOOZE_MIN);
          end else if (min_tick) begin
            if (cnt <= 6'd1) begin
              state_n = IDLE;
              cnt_n   = 6'd0;
            end else begin
              cnt_n = cnt - 6'd1;
            end
          end
        end
        SNOOZED: begin
          if (min_tick) begin
            if (cnt <= 6'd1) begin
              state_n = RINGING;
              cnt_n   = 6'(TIMEOUT_MIN);
            end else begin
              cnt_n = cnt - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ringing  = (state == RINGING);
  assign ring_nxt = (state_n == RINGING);

endmodule

// File: rtl/alarm_clock_multi.sv
// Time-of-day/day-of-week counter with N_ALARMS independent alarm slots.
// All outputs registered, updating on the pulse tick edge; no backpressure.
module alarm_clock_multi
  import alarm_clock_pkg::*;
#(
  parameter int N_ALARMS    = 4,
  parameter int SNOOZE_MIN  = 9,
  parameter int TIMEOUT_MIN = 10,
  parameter int SEL_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pulse,
  input  logic                timeset,
  input  logic                alarmset,
  input  logic                minadv,
  input  logic                hrsadv,
  input  logic                dayadv,
  input  logic [SEL_W-1:0]    alarm_sel,
  input  logic [6:0]          amask_in,
  input  logic [N_ALARMS-1:0] alarm_en,
  input  logic                alarmon,
  input  logic                snooze,
  output logic [6:0]          tsec,
  output logic [6:0]          tmin,
  output logic [6:0]          thrs,
  output logic [2:0]          tday,
  output logic [6:0]          amin_sel,
  output logic [6:0]          ahrs_sel,
  output logic [N_ALARMS-1:0] ring_vec,
  output logic                buzz
);

  logic                tset, aset, min_tick, snooze_q, snooze_edge;
  time_t               cur, nxt;
  logic [6:0]          amin_arr [N_ALARMS];
  logic [6:0]          ahrs_arr [N_ALARMS];
  logic [N_ALARMS-1:0] ring_nxt;
  logic [6:0]          mux_min, mux_hrs;

  assign tset        = timeset;
  assign aset        = !timeset && alarmset;
  assign snooze_edge = snooze && !snooze_q;

  always_comb begin
    nxt      = cur;
    min_tick = 1'b0;
    if (pulse) begin
      if (tset) begin
        nxt.sec = 7'd0;
        if (minadv) nxt.min = wrap_inc(cur.min, MIN_MOD);
        if (hrsadv) nxt.hrs = wrap_inc(cur.hrs, HRS_MOD);
        if (dayadv) nxt.day = 3'(wrap_inc({4'd0, cur.day}, DAY_MOD));
      end else begin
        nxt.sec = wrap_inc(cur.sec, SEC_MOD);
        if (cur.sec == 7'(SEC_MOD - 1)) begin
          min_tick = 1'b1;
          nxt.min  = wrap_inc(cur.min, MIN_MOD);
          if (cur.min == 7'(MIN_MOD - 1)) begin
            nxt.hrs = wrap_inc(cur.hrs, HRS_MOD);
            if (cur.hrs == 7'(HRS_MOD - 1)) nxt.day = 3'(wrap_inc({4'd0, cur.day}, DAY_MOD));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur      <= '0;
      snooze_q <= 1'b0;
    end else begin
      cur      <= nxt;
      snooze_q <= snooze;
    end
  end

  assign tsec = cur.sec;
  assign tmin = cur.min;
  assign thrs = cur.hrs;
  assign tday = cur.day;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    alarm_slot #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .TIMEOUT_MIN(TIMEOUT_MIN)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .edit       (aset && (alarm_sel == SEL_W'(i))),
      .pulse      (pulse),
      .minadv     (minadv),
      .hrsadv     (hrsadv),
      .mask_in    (amask_in),
      .arm        (alarm_en[i] && alarmon),
      .clr        (tset),
      .min_tick   (min_tick),
      .run_tick   (min_tick && !aset),
      .nxt        (nxt),
      .snooze_edge(snooze_edge),
      .amin       (amin_arr[i]),
      .ahrs       (ahrs_arr[i]),
      .ringing    (ring_vec[i]),
      .ring_nxt   (ring_nxt[i])
    );
  end

  // Out-of-range selects match no slot and so read back as zero.
  always_comb begin
    mux_min = 7'd0;
    mux_hrs = 7'd0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (alarm_sel == SEL_W'(i)) begin
        mux_min = amin_arr[i];
        mux_hrs = ahrs_arr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amin_sel <= 7'd0;
      ahrs_sel <= 7'd0;
      buzz     <= 1'b0;
    end else begin
      amin_sel <= mux_min;
      ahrs_sel <= mux_hrs;
      buzz     <= alarmon && (|ring_nxt);
    end
  end

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Scoreboard bench for alarm_clock_multi: expectations queued at stimulus, popped at observation.
module tb_alarm_clock_multi;

  logic       clk = 1'b0, rst = 1'b0, pulse = 1'b0;
  logic       timeset = 1'b0, alarmset = 1'b0, minadv = 1'b0, hrsadv = 1'b0, dayadv = 1'b0;
  logic [1:0] alarm_sel = 2'd0;
  logic [6:0] amask_in = 7'h7F;
  logic [3:0] alarm_en = 4'd0;
  logic       alarmon = 1'b0, snooze = 1'b0;
  logic [6:0] tsec, tmin, thrs, amin_sel, ahrs_sel;
  logic [2:0] tday;
  logic [3:0] ring_vec;
  logic       buzz;

  alarm_clock_multi dut (
    .clk(clk), .rst(rst), .pulse(pulse), .timeset(timeset), .alarmset(alarmset),
    .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv), .alarm_sel(alarm_sel),
    .amask_in(amask_in), .alarm_en(alarm_en), .alarmon(alarmon), .snooze(snooze),
    .tsec(tsec), .tmin(tmin), .thrs(thrs), .tday(tday), .amin_sel(amin_sel),
    .ahrs_sel(ahrs_sel), .ring_vec(ring_vec), .buzz(buzz)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] obs;
  int          mh = 0, mm = 0, ms = 0, md = 0;

  function automatic logic [31:0] ptime(int h, int m, int s, int d);
    return {8'd0, 3'(d), 7'(h), 7'(m), 7'(s)};
  endfunction

  task automatic model_tick();
    ms++;
    if (ms == 60) begin
      ms = 0; mm++;
      if (mm == 60) begin
        mm = 0; mh++;
        if (mh == 24) begin mh = 0; md = (md + 1) % 7; end
      end
    end
  endtask

  task automatic run_ticks(int n);
    pulse = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_tick();
    end
    #1 pulse = 1'b0;
  endtask

  task automatic tset_tick(bit ma, bit ha, bit da);
    timeset = 1'b1; minadv = ma; hrsadv = ha; dayadv = da; pulse = 1'b1;
    @(posedge clk);
    #1 pulse = 1'b0; minadv = 1'b0; hrsadv = 1'b0; dayadv = 1'b0;
    ms = 0;
    if (ma) mm = (mm + 1) % 60;
    if (ha) mh = (mh + 1) % 24;
    if (da) md = (md + 1) % 7;
  endtask

  task automatic goto_time(int h, int m, int d);
    tset_tick(0, 0, 0);
    while (mh != h) tset_tick(0, 1, 0);
    while (mm != m) tset_tick(1, 0, 0);
    while (md != d) tset_tick(0, 0, 1);
    timeset = 1'b0;
  endtask

  task automatic aset_tick(int sel, bit ma, bit ha);
    alarmset = 1'b1; alarm_sel = 2'(sel); minadv = ma; hrsadv = ha; pulse = 1'b1;
    @(posedge clk);
    model_tick();
    #1 pulse = 1'b0; minadv = 1'b0; hrsadv = 1'b0;
  endtask

  task automatic test_reset();
    exp_q.push_back(ptime(0, 0, 0, 0));
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs = {8'd0, tday, thrs, tmin, tsec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_time got=%h want=%h", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_ring got=%h want=%h", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = {18'd0, ahrs_sel, amin_sel}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_sel got=%h want=%h", obs, exp_v); end
    rst = 1'b1;
  endtask

  task automatic test_run();
    exp_q.push_back(ptime(1, 1, 1, 0));
    run_ticks(3661);
    exp_v = exp_q.pop_front(); obs = {8'd0, tday, thrs, tmin, tsec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL run_3661 got=%h want=%h", obs, exp_v); end
    goto_time(23, 59, 0);
    exp_q.push_back(ptime(0, 0, 0, 1));
    run_ticks(60);
    exp_v = exp_q.pop_front(); obs = {8'd0, tday, thrs, tmin, tsec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL day_rollover got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_alarm_timeout();
    amask_in = 7'h7F;
    for (int i = 0; i < 7; i++) aset_tick(2, 0, 1);
    for (int i = 0; i < 30; i++) aset_tick(2, 1, 0);
    alarmset = 1'b0;
    exp_q.push_back({18'd0, 7'd7, 7'd30});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs = {18'd0, ahrs_sel, amin_sel}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL sel_slot2 got=%h want=%h", obs, exp_v); end
    alarm_sel = 2'd0;
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs = {18'd0, ahrs_sel, amin_sel}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL sel_slot0 got=%h want=%h", obs, exp_v); end

    goto_time(7, 29, md);
    alarm_en = 4'b0100; alarmon = 1'b1;
    exp_q.push_back(ptime(7, 29, 59, md));
    exp_q.push_back(32'd0);
    run_ticks(59);
    exp_v = exp_q.pop_front(); obs = {8'd0, tday, thrs, tmin, tsec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pre_match_time got=%h want=%h", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pre_match_ring got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'h14);
    run_ticks(1);
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL match_ring got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'h14);
    run_ticks(540);
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL ring_9min got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'd0);
    run_ticks(60);
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL timeout got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_snooze();
    goto_time(7, 29, md);
    exp_q.push_back(32'h14);
    run_ticks(60);
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snooze_pre got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'd0);
    snooze = 1'b1;
    @(posedge clk); #1 snooze = 1'b0;
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snoozed got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'd0);
    run_ticks(480);
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snooze_8min got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'h14);
    run_ticks(60);
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL snooze_rering got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_alarmon_drop();
    exp_q.push_back(32'd0);
    alarmon = 1'b0;
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL alarmon_off got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'd0);
    alarmon = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL alarmon_restore got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_multi_mask();
    alarm_en = 4'd0;
    amask_in = 7'h7F;
    for (int i = 0; i < 6; i++) aset_tick(0, 0, 1);
    amask_in = 7'h7B;
    for (int i = 0; i < 6; i++) aset_tick(1, 0, 1);
    alarmset = 1'b0;
    amask_in = 7'h7F;
    goto_time(5, 59, 2);
    alarm_en = 4'b0011;
    exp_q.push_back(ptime(6, 0, 0, 2));
    exp_q.push_back(32'h11);
    run_ticks(60);
    exp_v = exp_q.pop_front(); obs = {8'd0, tday, thrs, tmin, tsec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL multi_time got=%h want=%h", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL multi_ring got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'd0);
    timeset = 1'b1;
    @(posedge clk); #1 timeset = 1'b0;
    exp_v = exp_q.pop_front(); obs = {27'd0, buzz, ring_vec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL tset_clears got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_tset_reset();
    int d0;
    goto_time(23, 59, md);
    run_ticks(40);
    d0 = md;
    alarm_sel = 2'd1;
    exp_q.push_back(ptime(2, 2, 0, d0));
    for (int i = 0; i < 3; i++) tset_tick(1, 1, 0);
    exp_v = exp_q.pop_front(); obs = {8'd0, tday, thrs, tmin, tsec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL tset_adv got=%h want=%h", obs, exp_v); end
    exp_q.push_back({18'd0, 7'd6, 7'd0});
    exp_v = exp_q.pop_front(); obs = {18'd0, ahrs_sel, amin_sel}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL sel_slot1 got=%h want=%h", obs, exp_v); end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_v = exp_q.pop_front(); obs = {8'd0, tday, thrs, tmin, tsec}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_rst_time got=%h want=%h", obs, exp_v); end
    exp_v = exp_q.pop_front(); obs = {13'd0, buzz, ring_vec, ahrs_sel, amin_sel}; total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_rst_out got=%h want=%h", obs, exp_v); end
    timeset = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run();
    test_alarm_timeout();
    test_snooze();
    test_alarmon_drop();
    test_multi_mask();
    test_tset_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised successor to the single-alarm clock top. Holds a time-of-day counter with day-of-week, plus N_ALARMS independent alarm slots. Each slot has its own minute, hour and day mask, and its own ring/snooze/timeout state machine. Binary outputs feed the existing lcd_int display drivers. Everything runs in one clk domain; `pulse` is a 1-cycle-per-second tick enable.

Parameters:
N_ALARMS, 4, number of alarm slots (1..8)
SNOOZE_MIN, 9, minutes a snoozed slot stays silent (1..63)
TIMEOUT_MIN, 10, minutes a ringing slot rings before self-cancelling (1..63)
SEL_W, $clog2(N_ALARMS) min 1, width of slot select

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pulse  in  1  1 Hz tick enable, high for one clk cycle
timeset  in  1  level: time-set mode
alarmset  in  1  level: alarm-set mode
minadv  in  1  level: advance minutes on each tick while in a set mode
hrsadv  in  1  level: advance hours on each tick while in a set mode
dayadv  in  1  level: advance day on each tick in time-set mode
alarm_sel  in  SEL_W  slot being edited or displayed
amask_in  in  7  day mask for the selected slot; bit0 = day 0
alarm_en  in  N_ALARMS  per-slot arm enable
alarmon  in  1  master alarm enable
snooze  in  1  snooze button, synchronous level
tsec  out  7  seconds, 0..59
tmin  out  7  minutes, 0..59
thrs  out  7  hours, 0..23
tday  out  3  day of week, 0..6
amin_sel  out  7  selected slot's alarm minute
ahrs_sel  out  7  selected slot's alarm hour
ring_vec  out  N_ALARMS  slots currently RINGING
buzz  out  1  alarmon & |ring_vec

Behaviour:
- Reset (rst low, asynchronous):
  - time = 00:00:00, day 0
  - all slots: 00:00, mask 7'h7F, state IDLE
  - snooze edge register cleared; ring_vec = 0; buzz = 0
- All state updates are on posedge clk. Counters change only on cycles with pulse=1; all outputs are registered.
- Mode select: timeset=1 → TSET (timeset wins when both are high); else alarmset=1 → ASET; else RUN.
- RUN, per tick:
  - sec increments mod 60.
  - Carry from 59 into min; min carries from 59 into hrs; hrs carries from 23 into day; day wraps 6→0.
  - min_tick is asserted on the tick where sec goes 59→0.
- TSET, per tick:
  - sec is forced to 0.
  - minadv: min +1 mod 60, no carry.
  - hrsadv: hrs +1 mod 24, no carry.
  - dayadv: day +1 mod 7.
  - No min_tick is generated.
- ASET:
  - Per tick, minadv/hrsadv advance the selected slot's minute/hour with the same wraps and no carry.
  - The selected slot's mask loads amask_in every clk cycle.
  - Time keeps running as in RUN.
- Match for slot i is asserted on a RUN min_tick when all hold, evaluated on post-increment time:
  - new min == amin[i]
  - new hrs == ahrs[i]
  - mask[i][new day] = 1
  - alarm_en[i] = 1
  - alarmon = 1
- Snooze edge: snooze 0→1, detected with one register.
- Per-slot FSM (IDLE, RINGING, SNOOZED) with a 6-bit minute counter cnt:
  - IDLE → RINGING on match; cnt = TIMEOUT_MIN.
  - RINGING → SNOOZED on snooze edge; cnt = SNOOZE_MIN.
  - RINGING → IDLE when cnt reaches 0. cnt decrements on each min_tick.
  - SNOOZED → RINGING when cnt reaches 0; cnt = TIMEOUT_MIN. cnt decrements on each min_tick.
  - Any state → IDLE immediately when alarm_en[i]=0 or alarmon=0. This has the highest priority.
  - Match in the same cycle as a snooze edge: match wins (RINGING, cnt = TIMEOUT_MIN).
  - Match while SNOOZED: re-arms to RINGING.
- Entering TSET forces all slots to IDLE.
- Reset mid-ring clears everything asynchronously.
- amin_sel/ahrs_sel: alarm_sel ≥ N_ALARMS reads 0; edits to such an index are ignored.

Decomposition:
- Package `alarm_clock_pkg`:
  - slot_state_e enum {IDLE, RINGING, SNOOZED}
  - constants SEC_MOD=60, MIN_MOD=60, HRS_MOD=24, DAY_MOD=7
  - time_t struct {sec, min, hrs, day}
- Sub-module `alarm_slot`:
  - holds one slot's min/hrs/mask registers, match compare, FSM and cnt
  - instantiated N_ALARMS times via generate
  - top owns the time counters, mode decode, snooze edge detect and the select mux.

Test Plan:
- Reset, then 3661 ticks in RUN → 01:01:01, day 0. At 86400 ticks → 00:00:00, day 1.
- ASET slot2 to 07:30 with mask 7'h7F, alarm_en=4'b0100, time 07:29:59, one tick → ring_vec=4'b0100, buzz=1. Let 10 more minute ticks pass → ring_vec=0.
- Ringing slot, snooze pulse → buzz=0. After 9 min_ticks → RINGING again, buzz=1.
- Slots 0 and 1 both set to 06:00, day mask bit for day 2 clear on slot 1, day 2 → only ring_vec[0] set.
- Ringing slot, alarmon dropped → buzz=0 next cycle, slot IDLE. Restoring alarmon → buzz stays 0.
- TSET held with minadv+hrsadv for 3 ticks from 23:59:40 → 02:02:00, day unchanged. Async rst mid-TSET → all outputs 0 immediately.
